spi_mem_ctrl_p: RTL and testbench

// Parametrised SPI master for the serial memory slave: one transaction per start pulse.

---
 rtl/spi_mem_if.sv | 40 ++++
 rtl/spi_mem_ctrl_p.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_mem_ctrl_p.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_if.sv
// ---------------------------------------------------------------------------
// spi_mem_if: bundle of host handshake and SPI pins for spi_mem_ctrl_p.
//   master : controller view (drives dout/busy/done/err, sclk/mosi/cs)
//   slave  : environment view (host request side plus the SPI slave pins)
// Host side : start, wr, cs_sel[CSW], addr[ADDR_W], din[DATA_W] -> dout, busy, done, err
// SPI side  : sclk, mosi, cs[NUM_CS] out; miso, ready, op_done in
// ---------------------------------------------------------------------------
interface spi_mem_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 2
);
    localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic              wr;
    logic [CSW-1:0]    cs_sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              busy;
    logic              done;
    logic              err;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_CS-1:0] cs;
    logic              ready;
    logic              op_done;

    modport master (
        input  start, wr, cs_sel, addr, din, miso, ready, op_done,
        output dout, busy, done, err, sclk, mosi, cs
    );

    modport slave (
        output start, wr, cs_sel, addr, din, miso, ready, op_done,
        input  dout, busy, done, err, sclk, mosi, cs
    );
endinterface

// File: rtl/spi_mem_ctrl_p.sv
// ---------------------------------------------------------------------------
// spi_mem_ctrl_p: SPI mode-0 master for a serial memory slave, one transaction
// per accepted start pulse. Frame {din, addr, wr} is shifted LSB first (reads
// omit din), then the controller waits for op_done (write) or ready (read) and
// for reads clocks DATA_W bits back from miso.
// Ports:
//   clk_i   : clock, all logic on posedge
//   rst_ni  : asynchronous active-low reset
//   bus     : spi_mem_if.master (start/wr/cs_sel/addr/din -> dout/busy/done/err,
//             sclk/mosi/cs out, miso/ready/op_done in)
// Optional feature: define SPI_TIMEOUT_EN to abort wait states after
// TIMEOUT_CYC cycles with a done+err pulse.
// ---------------------------------------------------------------------------
module spi_mem_ctrl_p #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned NUM_CS      = 2,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    spi_mem_if.master bus
);
    localparam int unsigned CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned RD_BITS = 1 + ADDR_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HALF    = CLK_DIV / 2;

    // Elaboration-time guard on the parameter set
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || NUM_CS < 1 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("spi_mem_ctrl_p: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE, CHECK, SHIFT_TX, WAIT_OPDONE, WAIT_READY, SHIFT_RX, ERROR, FINISH
    } state_e;

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic [CSW-1:0]      sel_q, sel_d;
    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                addr_bad_c;
    logic                sel_bad_c;
    logic                bit_end_c;
    logic                half_c;
    logic [BIT_W-1:0]    last_bit_c;
    logic [NUM_CS-1:0]   cs_on_c;
    logic                timeout_c;

    // Address is still intact in tx_q during CHECK (no shifting yet)
    assign addr_bad_c = {1'b0, tx_q[ADDR_W:1]} >= (ADDR_W + 1)'(DEPTH);
    assign sel_bad_c  = {1'b0, sel_q} >= (CSW + 1)'(NUM_CS);
    assign bit_end_c  = (div_q == DIV_W'(CLK_DIV - 1));
    assign half_c     = (div_q == DIV_W'(HALF - 1));
    assign last_bit_c = wr_q ? BIT_W'(FRAME_W - 1) : BIT_W'(RD_BITS - 1);
    assign cs_on_c    = ~(NUM_CS'(1) << sel_q);

`ifdef SPI_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;

    // Wait-state cycle counter, cleared whenever the FSM is not waiting
    always_comb begin
        to_d = '0;
        if (state_q == WAIT_OPDONE || state_q == WAIT_READY) begin
            to_d = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end

    assign timeout_c = (to_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            sel_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output logic; each bit is CLK_DIV cycles, low half then high half
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dout_d  = dout_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_d    = bus.wr;
                    sel_d   = bus.cs_sel;
                    tx_d    = {bus.din, bus.addr, bus.wr};
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (addr_bad_c || sel_bad_c) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    cs_d    = cs_on_c;
                    mosi_d  = tx_q[0];
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT_TX;
                end
            end
            SHIFT_TX: begin
                if (bit_end_c) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bit_q == last_bit_c) begin
                        mosi_d  = 1'b0;
                        cs_d    = '1;
                        bit_d   = '0;
                        state_d = wr_q ? WAIT_OPDONE : WAIT_READY;
                    end else begin
                        // Falling sclk edge: present the next bit
                        mosi_d = tx_q[1];
                        tx_d   = tx_q >> 1;
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                    if (half_c) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            WAIT_OPDONE: begin
                if (bus.op_done) begin
                    state_d = FINISH;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
            WAIT_READY: begin
                if (bus.ready) begin
                    cs_d    = cs_on_c;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT_RX;
                end else if (timeout_c) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end
            SHIFT_RX: begin
                if (bit_end_c) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        cs_d    = '1;
                        bit_d   = '0;
                        dout_d  = rx_q;
                        state_d = FINISH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                    if (half_c) begin
                        // Rising sclk edge: shift miso in from the top, LSB ends at bit 0
                        sclk_d = 1'b1;
                        rx_d   = DATA_W'({bus.miso, rx_q} >> 1);
                    end
                end
            end
            ERROR:   state_d = IDLE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == FINISH) || (state_d == ERROR);
        busy_d = (state_d != IDLE);
    end

    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.cs   = cs_q;
    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_spi_mem_ctrl_p.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_ctrl_p: directed bench for spi_mem_ctrl_p with default parameters.
// Acts as host and SPI slave; outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_spi_mem_ctrl_p;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_CS = 2;
    localparam int unsigned CSW    = 1;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    spi_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

    spi_mem_ctrl_p #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(32), .NUM_CS(NUM_CS),
        .CLK_DIV(4), .TIMEOUT_CYC(256)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic w, input logic [CSW-1:0] s,
                               input logic [7:0] a, input logic [7:0] d);
        bus.wr = w; bus.cs_sel = s; bus.addr = a; bus.din = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Record mosi at each sclk rise while cs is low; optional stray start at cycle glitch_at
    task automatic capture_tx(input int glitch_at, output logic [31:0] bits, output int nb,
                              output int cs_low, output logic [1:0] cs_seen, output bit to);
        logic prev;
        prev = 1'b0; bits = '0; nb = 0; cs_low = 0; cs_seen = 2'b11; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == glitch_at) begin
                bus.wr = 1'b0; bus.addr = 8'd7; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.cs != 2'b11) begin
                cs_low++;
                if (cs_seen == 2'b11) cs_seen = bus.cs;
            end else if (cs_low > 0) begin
                to = 1'b0;
                break;
            end
            if (bus.sclk && !prev) begin
                if (nb < 32) bits[nb] = bus.mosi;
                nb++;
            end
            prev = bus.sclk;
        end
        bus.start = 1'b0;
    endtask

    // Slave side of the read-back: present data LSB first during each sclk low phase
    task automatic capture_rx(input logic [7:0] data, output int cs_low, output int rises,
                              output bit to);
        logic prev;
        prev = 1'b0; cs_low = 0; rises = 0; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.ready = 1'b0;
            if (bus.cs != 2'b11) begin
                cs_low++;
            end else if (cs_low > 0) begin
                to = 1'b0;
                break;
            end
            if (bus.sclk && !prev) rises++;
            if (bus.cs != 2'b11 && !bus.sclk && rises < 8) bus.miso = data[rises];
            prev = bus.sclk;
        end
    endtask

    initial begin
        logic [31:0] bits;
        logic [1:0]  css;
        int          nb, csl, rises, n;
        bit          to, got, seen_sclk;

        n_assert = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.wr = 1'b0; bus.cs_sel = '0; bus.addr = '0; bus.din = '0;
        bus.miso = 1'b0; bus.ready = 1'b0; bus.op_done = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cs", 32'(bus.cs), 32'h3);
        check("rst_sclk", 32'(bus.sclk), 32'h0);
        check("rst_mosi", 32'(bus.mosi), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_dout", 32'(bus.dout), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write addr=5 din=A5 to slave 1, with a stray start mid-frame
        pulse_start(1'b1, 1'b1, 8'd5, 8'hA5);
        check("wr_busy_accept", 32'(bus.busy), 32'h1);
        check("wr_cs_check", 32'(bus.cs), 32'h3);
        capture_tx(10, bits, nb, csl, css, to);
        check("wr_tx_timeout", 32'(to), 32'h0);
        check("wr_bits", bits, 32'h14A0B);
        check("wr_nbits", 32'(nb), 32'd17);
        check("wr_cs_low_cycles", 32'(csl), 32'd68);
        check("wr_cs_value", 32'(css), 32'h1);
        tick(); tick();
        check("wr_wait_busy", 32'(bus.busy), 32'h1);
        check("wr_wait_done", 32'(bus.done), 32'h0);
        check("wr_wait_cs", 32'(bus.cs), 32'h3);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        check("wr_done", 32'(bus.done), 32'h1);
        check("wr_err", 32'(bus.err), 32'h0);
        check("wr_busy_at_done", 32'(bus.busy), 32'h1);
        check("wr_dout_unchanged", 32'(bus.dout), 32'h0);
        tick();
        check("wr_done_pulse", 32'(bus.done), 32'h0);
        check("wr_busy_low", 32'(bus.busy), 32'h0);
        // The stray start must not have queued a second frame
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cs != 2'b11 || bus.busy) got = 1'b1;
        end
        check("wr_no_second_frame", 32'(got), 32'h0);

        // Read addr=3 from slave 0, slave returns 3C
        pulse_start(1'b0, 1'b0, 8'd3, 8'hFF);
        capture_tx(-1, bits, nb, csl, css, to);
        check("rd_tx_timeout", 32'(to), 32'h0);
        check("rd_bits", bits, 32'h6);
        check("rd_nbits", 32'(nb), 32'd9);
        check("rd_cs_low_cycles", 32'(csl), 32'd36);
        check("rd_cs_value", 32'(css), 32'h2);
        tick(); tick();
        check("rd_gap_cs", 32'(bus.cs), 32'h3);
        check("rd_gap_busy", 32'(bus.busy), 32'h1);
        bus.ready = 1'b1;
        capture_rx(8'h3C, csl, rises, to);
        check("rd_rx_timeout", 32'(to), 32'h0);
        check("rd_rx_cs_low", 32'(csl), 32'd32);
        check("rd_rx_rises", 32'(rises), 32'd8);
        check("rd_done", 32'(bus.done), 32'h1);
        check("rd_err", 32'(bus.err), 32'h0);
        check("rd_dout", 32'(bus.dout), 32'h3C);
        tick();
        check("rd_busy_low", 32'(bus.busy), 32'h0);

        // Out-of-range address 40: done+err two cycles after start, no SPI activity
        pulse_start(1'b1, 1'b0, 8'd40, 8'h11);
        check("err40_done_early", 32'(bus.done), 32'h0);
        check("err40_busy", 32'(bus.busy), 32'h1);
        tick();
        check("err40_done", 32'(bus.done), 32'h1);
        check("err40_err", 32'(bus.err), 32'h1);
        check("err40_cs", 32'(bus.cs), 32'h3);
        check("err40_sclk", 32'(bus.sclk), 32'h0);
        tick();
        check("err40_done_pulse", 32'(bus.done), 32'h0);
        check("err40_err_pulse", 32'(bus.err), 32'h0);
        check("err40_busy_low", 32'(bus.busy), 32'h0);
        // Back-to-back start on first address past the end (32)
        pulse_start(1'b0, 1'b1, 8'd32, 8'h00);
        seen_sclk = bus.sclk;
        tick();
        if (bus.sclk) seen_sclk = 1'b1;
        check("err32_done", 32'(bus.done), 32'h1);
        check("err32_err", 32'(bus.err), 32'h1);
        check("err32_cs", 32'(bus.cs), 32'h3);
        check("err32_sclk_idle", 32'(seen_sclk), 32'h0);
        check("err32_dout_kept", 32'(bus.dout), 32'h3C);
        tick();

        // Reset in the middle of a write while sclk is high
        pulse_start(1'b1, 1'b0, 8'd9, 8'h5A);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i >= 8 && bus.sclk) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_sclk_high_found", 32'(got), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(bus.cs), 32'h3);
        check("mid_rst_sclk", 32'(bus.sclk), 32'h0);
        check("mid_rst_mosi", 32'(bus.mosi), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_dout", 32'(bus.dout), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1'b1, 1'b0, 8'd9, 8'h5A);
        capture_tx(-1, bits, nb, csl, css, to);
        check("post_rst_timeout", 32'(to), 32'h0);
        check("post_rst_bits", bits, 32'hB413);
        check("post_rst_nbits", 32'(nb), 32'd17);
        check("post_rst_cs_value", 32'(css), 32'h2);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        check("post_rst_done", 32'(bus.done), 32'h1);
        check("post_rst_err", 32'(bus.err), 32'h0);
        tick();

        // Read with ready never arriving
        pulse_start(1'b0, 1'b1, 8'd1, 8'h00);
        capture_tx(-1, bits, nb, csl, css, to);
        check("hang_tx_timeout", 32'(to), 32'h0);
        check("hang_bits", bits, 32'h2);
        n = 0; got = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus.done) begin
                n = i;
                got = 1'b1;
                break;
            end
        end
`ifdef SPI_TIMEOUT_EN
        check("to_wait_cycles", 32'(n), 32'd256);
        check("to_err", 32'(bus.err), 32'h1);
        check("to_cs", 32'(bus.cs), 32'h3);
        check("to_dout_kept", 32'(bus.dout), 32'h0);
`else
        check("hang_no_done", 32'(got), 32'h0);
        check("hang_busy", 32'(bus.busy), 32'h1);
        check("hang_cs", 32'(bus.cs), 32'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
